// File: rtl/softmax_out_writer_pkg.sv
// ---------------------------------------------------------------------------
// softmax_out_writer_pkg
// Shared definitions for the softmax write-back path:
//   - default widths, shared with the softmax top level
//   - write-back FSM state encoding (IDLE / RUN / DRAIN)
//   - packed memory word type at the default widths
// ---------------------------------------------------------------------------
package softmax_out_writer_pkg;

    localparam int DATAWIDTH_DEF  = 16;
    localparam int NUM_DEF        = 4;
    localparam int ADDRSIZE_DEF   = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wr_state_e;

    // Lane 0 sits in the least significant DATAWIDTH bits.
    typedef logic [DATAWIDTH_DEF*NUM_DEF-1:0] word_t;

endpackage

// File: rtl/softmax_out_writer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous flush.
// Ports:
//   clk, reset (sync, active-high), flush (sync, empties the FIFO)
//   push/wdata : write one entry; accepted when not full or popping this cycle
//   pop        : remove the head entry (ignored when empty)
//   rdata      : head entry; rdata_next : entry behind the head
//   count/full/empty : occupancy status
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == {CW{1'b0}});
    assign count      = count_q;
    assign rdata      = mem_q[rd_ptr_q];
    assign rdata_next = mem_q[rd_ptr_q + AW'(1)];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/softmax_out_writer.sv
// ---------------------------------------------------------------------------
// softmax_out_writer
// Write-back stage for the softmax engine: packs four result lanes into one
// word, buffers them, and writes consecutive memory addresses.
// Ports:
//   clk, reset (sync, active-high)
//   init, out_base_addr, num_words : start a run at a base address
//   in_valid, in_data0..3          : result lanes from the engine (no backpressure)
//   wr_en, wr_addr, wr_data, wr_ready : memory write port (held until wr_ready)
//   busy, complete, overflow       : run status; overflow is sticky per run
// The write register always mirrors the FIFO head, so the presented word is
// one of the FIFO_DEPTH buffered entries rather than an extra slot.
// ---------------------------------------------------------------------------
module softmax_out_writer
    import softmax_out_writer_pkg::*;
#(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int NUM        = NUM_DEF,
    parameter int ADDRSIZE   = ADDRSIZE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [ADDRSIZE-1:0]       out_base_addr,
    input  logic [ADDRSIZE-1:0]       num_words,
    input  logic                      in_valid,
    input  logic [DATAWIDTH-1:0]      in_data0,
    input  logic [DATAWIDTH-1:0]      in_data1,
    input  logic [DATAWIDTH-1:0]      in_data2,
    input  logic [DATAWIDTH-1:0]      in_data3,
    output logic                      wr_en,
    output logic [ADDRSIZE-1:0]       wr_addr,
    output logic [DATAWIDTH*NUM-1:0]  wr_data,
    input  logic                      wr_ready,
    output logic                      busy,
    output logic                      complete,
    output logic                      overflow
);

    localparam int WW = DATAWIDTH * NUM;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e           state_q, state_d;
    logic [ADDRSIZE-1:0] num_q, num_d;
    logic [ADDRSIZE-1:0] acc_q, acc_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDRSIZE-1:0] wr_addr_q, wr_addr_d;
    logic [WW-1:0]       wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                complete_q, complete_d;
    logic                overflow_q, overflow_d;

    logic [WW-1:0]       in_word_s;
    logic                push_req_s;
    logic                push_ok_s;
    logic                drop_s;
    logic                pop_s;
    logic [WW-1:0]       fifo_rdata_s;
    logic [WW-1:0]       fifo_rdata_next_s;
    logic [CW-1:0]       fifo_count_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    assign in_word_s = {in_data3, in_data2, in_data1, in_data0};

    // init takes priority: a word arriving alongside it belongs to no run.
    assign push_req_s = (state_q == ST_RUN) && !init && in_valid && (acc_q < num_q);
    assign pop_s      = wr_en_q && wr_ready;
    assign push_ok_s  = push_req_s && (!fifo_full_s || pop_s);
    assign drop_s     = push_req_s && fifo_full_s && !pop_s;

    sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (init),
        .push       (push_ok_s),
        .pop        (pop_s),
        .wdata      (in_word_s),
        .rdata      (fifo_rdata_s),
        .rdata_next (fifo_rdata_next_s),
        .count      (fifo_count_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Next-state for the FSM, counters, write register and status flags.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        acc_d      = acc_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        complete_d = 1'b0;
        overflow_d = overflow_q;
        if (init) begin
            num_d      = num_words;
            acc_d      = {ADDRSIZE{1'b0}};
            wr_addr_d  = out_base_addr;
            wr_en_d    = 1'b0;
            overflow_d = 1'b0;
            if (num_words == {ADDRSIZE{1'b0}}) begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                complete_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                busy_d  = 1'b1;
            end
        end else begin
            if (pop_s) begin
                wr_addr_d = wr_addr_q + ADDRSIZE'(1);
            end else begin
                wr_addr_d = wr_addr_q;
            end
            // Dropped words still count so a stalled run can terminate.
            if (push_req_s) begin
                acc_d = acc_q + ADDRSIZE'(1);
            end else begin
                acc_d = acc_q;
            end
            if (drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            // Present the FIFO head as it will be after this cycle's push/pop.
            if (pop_s) begin
                if (fifo_count_s > CW'(1)) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = fifo_rdata_next_s;
                end else if (push_ok_s) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_word_s;
                end else begin
                    wr_en_d   = 1'b0;
                    wr_data_d = wr_data_q;
                end
            end else if (fifo_empty_s) begin
                if (push_ok_s) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_word_s;
                end else begin
                    wr_en_d   = 1'b0;
                    wr_data_d = wr_data_q;
                end
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = fifo_rdata_s;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (push_req_s && (acc_d == num_q)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s || ((fifo_count_s == CW'(1)) && pop_s)) begin
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        complete_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            num_q      <= {ADDRSIZE{1'b0}};
            acc_q      <= {ADDRSIZE{1'b0}};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDRSIZE{1'b0}};
            wr_data_q  <= {WW{1'b0}};
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign complete = complete_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_softmax_out_writer.sv
// ---------------------------------------------------------------------------
// tb_softmax_out_writer
// Self-checking bench: a directed vector table, hand-written corner-case
// sequences and a randomized phase, all compared every cycle against a
// queue-based model of the write-back behaviour.
// ---------------------------------------------------------------------------
module tb_softmax_out_writer;
    import softmax_out_writer_pkg::*;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset, init, in_valid, wr_ready;
    logic [7:0]  out_base_addr, num_words;
    logic [15:0] in_data0, in_data1, in_data2, in_data3;
    logic        wr_en, busy, complete, overflow;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;

    int checks = 0;
    int errors = 0;

    // Model state.
    word_t      mq[$];
    logic       m_active, m_complete, m_overflow;
    logic [7:0] m_acc, m_num, m_addr;

    // Observed write statistics for the directed sequences.
    int         n_writes;
    logic [7:0] last_addr, first_addr;

    typedef struct {
        logic        init;
        logic [7:0]  base;
        logic [7:0]  num;
        logic        v;
        logic [15:0] k;
        logic        rdy;
        logic        e_en;
        logic [7:0]  e_addr;
        logic [15:0] e_k;
        logic        e_busy;
        logic        e_comp;
    } vec_t;

    vec_t tbl [9];

    softmax_out_writer dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .out_base_addr (out_base_addr),
        .num_words     (num_words),
        .in_valid      (in_valid),
        .in_data0      (in_data0),
        .in_data1      (in_data1),
        .in_data2      (in_data2),
        .in_data3      (in_data3),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .complete      (complete),
        .overflow      (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic word_t lanes(input logic [15:0] k);
        return {k + 16'd3, k + 16'd2, k + 16'd1, k};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue model: the queue holds every buffered word including the one on
    // the write port; the head is written when the memory is ready.
    task automatic model_step();
        int sz;
        bit pop;
        bit preq;
        m_complete = 1'b0;
        if (reset) begin
            mq.delete();
            m_active = 1'b0; m_overflow = 1'b0;
            m_acc = 8'd0; m_num = 8'd0; m_addr = 8'd0;
        end else if (init) begin
            mq.delete();
            m_overflow = 1'b0; m_acc = 8'd0;
            m_num = num_words; m_addr = out_base_addr;
            if (num_words == 8'd0) begin
                m_active = 1'b0; m_complete = 1'b1;
            end else begin
                m_active = 1'b1;
            end
        end else begin
            sz   = mq.size();
            pop  = (sz != 0) && wr_ready;
            preq = m_active && (m_acc < m_num) && in_valid;
            if (pop) begin
                void'(mq.pop_front());
                m_addr = m_addr + 8'd1;
            end
            if (preq) begin
                m_acc = m_acc + 8'd1;
                if (sz == FD && !pop) m_overflow = 1'b1;
                else mq.push_back({in_data3, in_data2, in_data1, in_data0});
            end
            if (m_active && m_acc == m_num && mq.size() == 0) begin
                m_active = 1'b0; m_complete = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        chk("wr_en", {63'd0, wr_en}, {63'd0, mq.size() != 0});
        chk("wr_addr", {56'd0, wr_addr}, {56'd0, m_addr});
        if (mq.size() != 0) chk("wr_data", wr_data, mq[0]);
        chk("busy", {63'd0, busy}, {63'd0, m_active});
        chk("complete", {63'd0, complete}, {63'd0, m_complete});
        chk("overflow", {63'd0, overflow}, {63'd0, m_overflow});
    endtask

    // One clock: drive inputs, record any handshake, advance model, compare.
    task automatic cycle(input logic i_rst, input logic i_init, input logic [7:0] i_base,
                         input logic [7:0] i_num, input logic i_v, input word_t i_w,
                         input logic i_rdy);
        reset = i_rst; init = i_init; out_base_addr = i_base; num_words = i_num;
        in_valid = i_v; wr_ready = i_rdy;
        in_data0 = i_w[15:0]; in_data1 = i_w[31:16]; in_data2 = i_w[47:32]; in_data3 = i_w[63:48];
        if (wr_en && wr_ready && !reset && !init) begin
            if (n_writes == 0) first_addr = wr_addr;
            last_addr = wr_addr;
            n_writes++;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 64'd0, rdy);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; out_base_addr = 8'd0; num_words = 8'd0;
        in_valid = 1'b0; wr_ready = 1'b0;
        in_data0 = 16'd0; in_data1 = 16'd0; in_data2 = 16'd0; in_data3 = 16'd0;
        n_writes = 0; last_addr = 8'd0; first_addr = 8'd0;
        mq.delete();
        m_active = 1'b0; m_complete = 1'b0; m_overflow = 1'b0;
        m_acc = 8'd0; m_num = 8'd0; m_addr = 8'd0;

        @(negedge clk);
        cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 64'd0, 1'b0);
        chk("reset wr_data", wr_data, 64'd0);

        // Basic run, then a zero-count init.
        tbl[0] = '{1'b1, 8'h10, 8'd4, 1'b0, 16'd0,  1'b1, 1'b0, 8'h00, 16'd0,  1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'd1,  1'b1, 1'b1, 8'h10, 16'd1,  1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'd5,  1'b1, 1'b1, 8'h11, 16'd5,  1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'd9,  1'b1, 1'b1, 8'h12, 16'd9,  1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'd13, 1'b1, 1'b1, 8'h13, 16'd13, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'd0,  1'b1, 1'b0, 8'h00, 16'd0,  1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'd0,  1'b1, 1'b0, 8'h00, 16'd0,  1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h77, 8'd0, 1'b0, 16'd0,  1'b1, 1'b0, 8'h00, 16'd0,  1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'd0,  1'b1, 1'b0, 8'h00, 16'd0,  1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, tbl[i].init, tbl[i].base, tbl[i].num, tbl[i].v, lanes(tbl[i].k), tbl[i].rdy);
            chk($sformatf("tbl[%0d] wr_en", i), {63'd0, wr_en}, {63'd0, tbl[i].e_en});
            if (tbl[i].e_en) begin
                chk($sformatf("tbl[%0d] wr_addr", i), {56'd0, wr_addr}, {56'd0, tbl[i].e_addr});
                chk($sformatf("tbl[%0d] wr_data", i), wr_data, lanes(tbl[i].e_k));
            end
            chk($sformatf("tbl[%0d] busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
            chk($sformatf("tbl[%0d] complete", i), {63'd0, complete}, {63'd0, tbl[i].e_comp});
        end
        chk("first word", {48'd0, 16'd1} | (lanes(16'd1) & 64'hFFFF_FFFF_FFFF_0000), 64'h0004_0003_0002_0001);

        // Stall mid-stream for three cycles.
        n_writes = 0;
        cycle(1'b0, 1'b1, 8'h20, 8'd6, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, lanes(16'd100 + 16'(4 * i)), !(i >= 2 && i <= 4));
        idle(8, 1'b1);
        chk("stall writes", 64'(n_writes), 64'd6);
        chk("stall overflow", {63'd0, overflow}, 64'd0);

        // Overflow: six pushes into a stalled port.
        n_writes = 0;
        cycle(1'b0, 1'b1, 8'h30, 8'd6, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, lanes(16'h200 + 16'(4 * i)), 1'b0);
        idle(8, 1'b1);
        chk("ovf writes", 64'(n_writes), 64'd4);
        chk("ovf last addr", {56'd0, last_addr}, 64'h33);
        chk("ovf sticky", {63'd0, overflow}, 64'd1);
        chk("ovf busy", {63'd0, busy}, 64'd0);

        // Address wrap, with extra pushes after the count is reached.
        n_writes = 0;
        cycle(1'b0, 1'b1, 8'hFE, 8'd3, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, lanes(16'h300 + 16'(4 * i)), 1'b1);
        idle(4, 1'b1);
        chk("wrap writes", 64'(n_writes), 64'd3);
        chk("wrap last addr", {56'd0, last_addr}, 64'h00);
        chk("wrap overflow", {63'd0, overflow}, 64'd0);

        // Restart mid-run after an overflow.
        cycle(1'b0, 1'b1, 8'h50, 8'd8, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, lanes(16'h400 + 16'(4 * i)), 1'b0);
        chk("pre-restart overflow", {63'd0, overflow}, 64'd1);
        n_writes = 0;
        cycle(1'b0, 1'b1, 8'h40, 8'd4, 1'b0, 64'd0, 1'b0);
        chk("restart overflow", {63'd0, overflow}, 64'd0);
        chk("restart wr_en", {63'd0, wr_en}, 64'd0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, lanes(16'h500 + 16'(4 * i)), 1'b1);
        idle(4, 1'b1);
        chk("restart first addr", {56'd0, first_addr}, 64'h40);
        chk("restart writes", 64'(n_writes), 64'd4);

        // Reset in the middle of a run.
        cycle(1'b0, 1'b1, 8'h60, 8'd5, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, lanes(16'h600 + 16'(4 * i)), 1'b0);
        cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 64'd0, 1'b0);
        chk("rst wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst wr_addr", {56'd0, wr_addr}, 64'd0);
        chk("rst wr_data", wr_data, 64'd0);
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst complete", {63'd0, complete}, 64'd0);
        chk("rst overflow", {63'd0, overflow}, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_init, r_v, r_rdy;
            r_rst  = ($urandom_range(0, 299) == 0);
            r_init = ($urandom_range(0, 24) == 0);
            r_v    = ($urandom_range(0, 9) < 7);
            r_rdy  = ($urandom_range(0, 9) < 6);
            cycle(r_rst, r_init, 8'($urandom), 8'($urandom_range(0, 10)), r_v,
                  {32'($urandom), 32'($urandom)}, r_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
